// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small instruction store and issues a run of
// words from address 0 to the datapath over a valid/ready handshake.
module instr_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [19:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   count,
  input  logic          instr_ready,
  output logic [19:0]   instr_out,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   bad_sel_cnt
);

  localparam int DATA_W = 20;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0]   MAX_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  logic [DATA_W-1:0] r_store [DEPTH];
  logic [1:0]        r_state;
  logic [AW-1:0]     r_pc;
  logic [AW:0]       r_issued;
  logic [AW:0]       r_run_len;
  logic [AW:0]       r_bad_cnt;
  logic [DATA_W-1:0] r_instr_p1;

  logic        w_idle;
  logic [AW:0] w_issued_nxt;

  function automatic logic sel_illegal(input logic [2:0] sel);
    return (sel == 3'b011) || (sel == 3'b101);
  endfunction

  // Illegal-sel words still issue, but must never write a result.
  function automatic logic [DATA_W-1:0] sanitize(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] o;
    o = w;
    if (sel_illegal(w[12:10])) o[18] = 1'b0;
    return o;
  endfunction

  assign w_idle       = (r_state == S_IDLE);
  assign w_issued_nxt = r_issued + CNT_ONE;

  // Store is never cleared by reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (!rst && w_idle && load_we) r_store[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_issued   <= '0;
      r_run_len  <= '0;
      r_bad_cnt  <= '0;
      r_instr_p1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state   <= S_FETCH;
              r_pc      <= '0;
              r_issued  <= '0;
              r_bad_cnt <= '0;
              r_run_len <= (count > MAX_LEN) ? MAX_LEN : count;
            end
          end
        end
        // fetch -> issue register (p1)
        S_FETCH: begin
          r_instr_p1 <= sanitize(r_store[r_pc]);
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (instr_ready) begin
            r_issued <= w_issued_nxt;
            if (sel_illegal(r_instr_p1[12:10])) r_bad_cnt <= r_bad_cnt + CNT_ONE;
            if (w_issued_nxt == r_run_len) begin
              r_state <= S_DONE;
            end else begin
              r_pc    <= r_pc + PC_ONE;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_out   = r_instr_p1;
  assign instr_valid = (r_state == S_ISSUE);
  assign pc          = r_pc;
  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign done        = (r_state == S_DONE);
  assign bad_sel_cnt = r_bad_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-computed words, handshake timing,
// stalls, illegal-sel handling, run-length edges and reset behaviour.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        load_we;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic [5:0]  count;
  logic        instr_ready;
  logic [19:0] instr_out;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic [5:0]  bad_sel_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [19:0] got [64];
  logic [19:0] w_ref [4];

  instr_sequencer #(.DEPTH(32), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .count      (count),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .bad_sel_cnt(bad_sel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_chk++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [19:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  // Records every handshake until done is seen; returns in the DONE cycle.
  task automatic collect(output int n);
    int cyc;
    n   = 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (instr_valid && instr_ready && n < 64) begin
        got[n] = instr_out;
        n++;
      end
      tick();
      cyc++;
    end
    if (cyc >= 200) check("collect_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic run(input logic [5:0] cnt, output int n);
    count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(n);
  endtask

  initial begin
    int n;
    int errs;
    logic stable;
    logic [19:0] a0, e0, a1, a2, e2;

    w_ref[0] = 20'h44405;
    w_ref[1] = 20'h44426;
    w_ref[2] = 20'h44847;
    w_ref[3] = 20'h45868;

    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; count = '0; instr_ready = 1'b1;
    tick();
    tick();
    check("rst_out",   32'(instr_out),   32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc",    32'(pc),          32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_bad",   32'(bad_sel_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) load_word(5'(i), w_ref[i]);

    // Basic run: valid every other cycle, first valid two cycles after start.
    count = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_fetch", 32'(busy),        32'd1);
    check("t1_vld_fetch",  32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_vld", 32'(instr_valid), 32'd1);
      check("t1_out", 32'(instr_out),   32'(w_ref[i]));
      check("t1_pc",  32'(pc),          32'(i));
      tick();
      if (i < 3) begin
        check("t1_gap_vld", 32'(instr_valid), 32'd0);
      end else begin
        check("t1_done",     32'(done),        32'd1);
        check("t1_done_vld", 32'(instr_valid), 32'd0);
        check("t1_bad",      32'(bad_sel_cnt), 32'd0);
        check("t1_pc_final", 32'(pc),          32'd3);
      end
    end
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle_busy",  32'(busy), 32'd0);

    // Stall: ready low for 5 cycles in ISSUE.
    instr_ready = 1'b0;
    count = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t2_vld", 32'(instr_valid), 32'd1);
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!(instr_out == w_ref[0] && instr_valid && pc == 5'd0)) stable = 1'b0;
    end
    check("t2_stall_hold", 32'(stable), 32'd1);
    instr_ready = 1'b1;
    collect(n);
    check("t2_n", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_word", 32'(got[i]), 32'(w_ref[i]));
    tick();

    // Reset mid-handshake of the third instruction; load/start during reset ignored.
    count = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("t5_pre_out", 32'(instr_out), 32'(w_ref[2]));
    rst = 1'b1; load_we = 1'b1; load_addr = 5'd0; load_data = 20'hFFFFF;
    start = 1'b1; count = 6'd2;
    tick();
    rst = 1'b0; load_we = 1'b0; start = 1'b0;
    check("t5_out",   32'(instr_out),   32'd0);
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_pc",    32'(pc),          32'd0);
    check("t5_busy",  32'(busy),        32'd0);
    check("t5_done",  32'(done),        32'd0);
    check("t5_bad",   32'(bad_sel_cnt), 32'd0);
    tick();
    check("t5_start_ignored", 32'(busy), 32'd0);
    run(6'd2, n);
    check("t5_n",  32'(n),      32'd2);
    check("t5_w0", 32'(got[0]), 32'(w_ref[0]));
    check("t5_w1", 32'(got[1]), 32'(w_ref[1]));
    check("t5_pc", 32'(pc),     32'd1);
    tick();

    // load_we while busy must not touch the store.
    count = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_we = 1'b1; load_addr = 5'd1; load_data = 20'h00000;
    collect(n);
    load_we = 1'b0;
    tick();
    run(6'd2, n);
    check("t6_n",  32'(n),      32'd2);
    check("t6_w1", 32'(got[1]), 32'(w_ref[1]));
    tick();

    // Illegal sel codes: bit18 cleared, counted at handshake.
    a0 = {1'b0, 1'b1, 5'd3,  3'b011, 5'd7, 5'd9};
    e0 = {1'b0, 1'b0, 5'd3,  3'b011, 5'd7, 5'd9};
    a1 = {1'b1, 1'b1, 5'd4,  3'b111, 5'd5, 5'd6};
    a2 = {1'b1, 1'b1, 5'd31, 3'b101, 5'd1, 5'd2};
    e2 = {1'b1, 1'b0, 5'd31, 3'b101, 5'd1, 5'd2};
    load_word(5'd0, a0);
    run(6'd1, n);
    check("t3_n1",   32'(n),           32'd1);
    check("t3_w0",   32'(got[0]),      32'(e0));
    check("t3_bad1", 32'(bad_sel_cnt), 32'd1);
    tick();
    load_word(5'd1, a1);
    load_we = 1'b1; load_addr = 5'd2; load_data = a2;
    count = 6'd3; start = 1'b1;
    tick();
    load_we = 1'b0; start = 1'b0;
    collect(n);
    check("t3_n3",   32'(n),           32'd3);
    check("t3_x0",   32'(got[0]),      32'(e0));
    check("t3_x1",   32'(got[1]),      32'(a1));
    check("t3_x2",   32'(got[2]),      32'(e2));
    check("t3_bad2", 32'(bad_sel_cnt), 32'd2);
    tick();
    check("t3_bad_hold", 32'(bad_sel_cnt), 32'd2);

    // Run-length edges: zero and over-length clamp.
    for (int i = 0; i < 32; i++) load_word(5'(i), 20'h10000 | 20'(i));
    count = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_zero_done", 32'(done),        32'd1);
    check("t4_zero_vld",  32'(instr_valid), 32'd0);
    check("t4_zero_busy", 32'(busy),        32'd0);
    tick();
    check("t4_zero_pulse", 32'(done),        32'd0);
    check("t4_zero_vld2",  32'(instr_valid), 32'd0);
    run(6'd40, n);
    check("t4_clamp_n", 32'(n), 32'd32);
    errs = 0;
    for (int i = 0; i < 32; i++) if (got[i] !== (20'h10000 | 20'(i))) errs++;
    check("t4_clamp_words", 32'(errs),        32'd0);
    check("t4_clamp_pc",    32'(pc),          32'd31);
    check("t4_clamp_bad",   32'(bad_sel_cnt), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
